// File: rtl/seg7_scan_display.sv
// Multiplexed 8-digit hex 7-segment driver with a per-frame snapshot of the value.
// Optional LEADING_ZERO_BLANK_EN: suppress digits above the highest nonzero nibble.
module seg7_scan_display #(
  parameter int unsigned DIV = 1000,
  parameter int unsigned GAP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [7:0]  dig_sel,
  output logic        frame
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef logic [PW-1:0] pcnt_t;
  localparam pcnt_t PLAST = pcnt_t'(DIV - 1);
  localparam pcnt_t PGAP  = pcnt_t'(GAP);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  pcnt_t       pcnt_q, pcnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] shadow_q, shadow_d;
  logic        snap_q, snap_d;
  logic [6:0]  seg_q, seg_d;
  logic [7:0]  dig_q, dig_d;
  logic        frame_q, frame_d;
  logic        tick, lit;

`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0]  top_q, top_d;

  function automatic logic [2:0] top_of(input logic [31:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (v[4*i +: 4] != 4'h0) r = 3'(i);
    return r;
  endfunction
`endif

  always_comb begin
    tick     = (pcnt_q == PLAST);
    pcnt_d   = tick ? '0 : pcnt_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = shadow_q;
    snap_d   = snap_q;
`ifdef LEADING_ZERO_BLANK_EN
    top_d    = top_q;
`endif
    // Snapshot lands on the same edge that wraps idx back to digit 0.
    if (tick && idx_q == 3'd7) begin
      shadow_d = value;
      snap_d   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      top_d    = top_of(value);
`endif
    end

    lit = !blank && (pcnt_q >= PGAP);
`ifdef LEADING_ZERO_BLANK_EN
    lit = lit && (idx_q <= top_q);
`endif
    dig_d   = lit ? (8'h01 << idx_q) : '0;
    seg_d   = lit ? hex7(shadow_q[{idx_q, 2'b00} +: 4]) : '0;
    frame_d = snap_q && (idx_q == 3'd0) && (pcnt_q == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pcnt_q   <= '0;
      idx_q    <= 3'd7;
      shadow_q <= '0;
      snap_q   <= 1'b0;
      seg_q    <= '0;
      dig_q    <= '0;
      frame_q  <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      top_q    <= '0;
`endif
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      snap_q   <= snap_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      frame_q  <= frame_d;
`ifdef LEADING_ZERO_BLANK_EN
      top_q    <= top_d;
`endif
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (DIV=8, GAP=2) against a cycle-count reference model.
module tb_seg7_scan_display;
  localparam int DIV = 8;
  localparam int GAP = 2;

  logic        clock;
  logic        reset;
  logic [31:0] value;
  logic        blank;
  logic [6:0]  seg;
  logic [7:0]  dig_sel;
  logic        frame;

  int checks = 0;
  int errors = 0;
  logic [7:0] lit_mask;
  int frame_cnt;

  seg7_scan_display #(.DIV(DIV), .GAP(GAP)) dut (
    .clock(clock), .reset(reset), .value(value), .blank(blank),
    .seg(seg), .dig_sel(dig_sel), .frame(frame)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: display state derived from the number of clocks since reset release.
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_t;
  logic [31:0] m_sh;
  bit          m_snapped;
  int          m_top;
  logic [6:0]  e_seg;
  logic [7:0]  e_dig;
  logic        e_frame;

  function automatic int pc_of(int t);
    return (t < DIV) ? t : (t - DIV) % DIV;
  endfunction

  function automatic int ix_of(int t);
    return (t < DIV) ? 7 : ((t - DIV) / DIV) % 8;
  endfunction

  function automatic int top_ref(logic [31:0] v);
    int r = 0;
    for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) r = i;
    return r;
  endfunction

  function automatic bit lit_ref(int t, bit b, int top);
    bit on = !b && (pc_of(t) >= GAP);
`ifdef LEADING_ZERO_BLANK_EN
    on = on && (ix_of(t) <= top);
`endif
    return on;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_t <= 0; m_sh <= '0; m_snapped <= 0; m_top <= 0;
      e_seg <= '0; e_dig <= '0; e_frame <= 1'b0;
    end else begin
      e_dig   <= lit_ref(m_t, blank, m_top) ? 8'(1 << ix_of(m_t)) : 8'h00;
      e_seg   <= lit_ref(m_t, blank, m_top) ? tbl[(m_sh >> (4 * ix_of(m_t))) & 32'hF] : 7'h00;
      e_frame <= m_snapped && ix_of(m_t) == 0 && pc_of(m_t) == 0;
      if (pc_of(m_t) == DIV - 1 && ix_of(m_t) == 7) begin
        m_sh <= value; m_snapped <= 1; m_top <= top_ref(value);
      end
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      chk("seg", 32'(seg), 32'(e_seg));
      chk("dig_sel", 32'(dig_sel), 32'(e_dig));
      chk("frame", 32'(frame), 32'(e_frame));
      chk("onehot0", 32'($onehot0(dig_sel)), 32'd1);
      lit_mask |= dig_sel;
      if (frame === 1'b1) frame_cnt++;
    end
  endtask

  initial begin
    int fc0;
    bit found;
    reset = 1'b0; value = 32'h12345678; blank = 1'b0;
    lit_mask = '0; frame_cnt = 0;
    #1;
    chk("reset_seg", 32'(seg), 32'h0);
    chk("reset_dig", 32'(dig_sel), 32'h0);
    chk("reset_frame", 32'(frame), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Bring-up timing from release
    run(9);  chk("t1_frame9", 32'(frame), 32'h1); chk("t1_dig9", 32'(dig_sel), 32'h0);
    run(2);  chk("t1_dig11", 32'(dig_sel), 32'h01); chk("t1_seg11", 32'(seg), 32'h7F);
    run(5);  chk("t1_dig16", 32'(dig_sel), 32'h01); chk("t1_seg16", 32'(seg), 32'h7F);
    run(3);  chk("t1_dig19", 32'(dig_sel), 32'h02); chk("t1_seg19", 32'(seg), 32'h07);
    run(48); chk("t1_dig67", 32'(dig_sel), 32'h80); chk("t1_seg67", 32'(seg), 32'h06);

    // Snapshot isolation: change during digit 3 of the next frame
    run(31); value = 32'hFFFFFFFF;
    run(18); chk("t2_dig116", 32'(dig_sel), 32'h20); chk("t2_seg116", 32'(seg), 32'h4F);
    run(24); chk("t2_dig140", 32'(dig_sel), 32'h01); chk("t2_seg140", 32'(seg), 32'h71);

    // Encoding sweep
    value = 32'hFEDCBA98; run(128);
    value = 32'h76543210; run(128);

    // Blank across frame boundaries
    blank = 1'b1; run(2);
    lit_mask = '0; fc0 = frame_cnt;
    run(128);
    chk("t4_blank_mask", 32'(lit_mask), 32'h0);
    chk("t4_frames", 32'(frame_cnt - fc0), 32'd2);
    blank = 1'b0; run(70);

    // Reset pulse during digit 5
    value = 32'h87654321;
    run(70);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (dig_sel === 8'h20) found = 1;
      else run(1);
    end
    chk("t5_reach_dig5", 32'(found), 32'd1);
    reset = 1'b0; #1;
    chk("t5_rst_seg", 32'(seg), 32'h0);
    chk("t5_rst_dig", 32'(dig_sel), 32'h0);
    chk("t5_rst_frame", 32'(frame), 32'h0);
    @(negedge clock); reset = 1'b1;
    run(10); chk("t5_dig10", 32'(dig_sel), 32'h00);
    run(1);  chk("t5_dig11", 32'(dig_sel), 32'h01);
    run(60);

    // Randomized value and blank traffic
    for (int k = 0; k < 40; k++) begin
      value = $urandom;
      if ($urandom_range(0, 3) == 0) value = value & 32'h0000FFFF;
      blank = ($urandom_range(0, 5) == 0);
      run($urandom_range(1, 60));
    end
    blank = 1'b0;

    // Leading-zero behaviour
    value = 32'h000000A0; run(66);
    lit_mask = '0; run(64);
`ifdef LEADING_ZERO_BLANK_EN
    chk("t6_mask_A0", 32'(lit_mask), 32'h03);
`else
    chk("t6_mask_A0", 32'(lit_mask), 32'hFF);
`endif
    value = 32'h0; run(66);
    lit_mask = '0; run(64);
`ifdef LEADING_ZERO_BLANK_EN
    chk("t6_mask_0", 32'(lit_mask), 32'h01);
`else
    chk("t6_mask_0", 32'(lit_mask), 32'hFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
